// File: rtl/uart_tx_pkt_arbiter_pkg.sv
// Shared types and helpers for the UART TX packet arbiter.
// Packet framing is header | payload | XOR checksum trailer.
package uart_tx_pkt_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HEADER,
        ARB_PAYLOAD,
        ARB_TRAILER
    } arb_state_t;

    localparam logic [3:0] HDR_MAGIC_DEF = 4'hA;
    localparam int         CHK_MAX_W     = 16;

    // Running checksum step; callers zero-extend narrower bytes to CHK_MAX_W.
    function automatic logic [CHK_MAX_W-1:0] chk_fold(
        input logic [CHK_MAX_W-1:0] chk,
        input logic [CHK_MAX_W-1:0] data
    );
        return chk ^ data;
    endfunction

endpackage

// File: rtl/uart_tx_pkt_arbiter_rr_arb.sv
// Combinational rotating-priority select: first asserted request at or after
// ptr, wrapping modulo NUM_REQ.
module uart_tx_pkt_arbiter_rr_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [3:0]         ptr,
    output logic [3:0]         grant,
    output logic               any_valid
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [4:0]           idx;

    // ptr is always < NUM_REQ, so shifting the doubled vector rotates it.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && req_rot[i]) begin
                any_valid = 1'b1;
                idx       = {1'b0, ptr} + 5'(i);
                if (idx >= 5'(NUM_REQ)) begin
                    idx = idx - 5'(NUM_REQ);
                end
                grant = idx[3:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_pkt_arbiter.sv
// Round-robin packet arbiter feeding the shared UART TX byte FIFO; one source
// owns the FIFO from header until its checksum trailer is written.
module uart_tx_pkt_arbiter
    import uart_tx_pkt_arbiter_pkg::*;
#(
    parameter int         NUM_REQ     = 2,
    parameter int         DATA_W      = 8,
    parameter logic [3:0] HDR_MAGIC   = HDR_MAGIC_DEF,
    parameter int         MAX_PKT_LEN = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]          i_req_last,
    output logic [NUM_REQ-1:0]          o_req_ready,
    input  logic                        i_fifo_full,
    output logic                        o_fifo_wr_en,
    output logic [DATA_W-1:0]           o_fifo_wr_data,
    output logic                        o_busy,
    output logic [3:0]                  o_grant_id,
    output logic                        o_err_trunc
);

    arb_state_t        state_q, state_d;
    logic [3:0]        rr_ptr_q, rr_ptr_d;
    logic [3:0]        grant_id_q, grant_id_d;
    logic [DATA_W-1:0] chk_q, chk_d;
    logic [7:0]        len_q, len_d;
    logic              err_trunc_q, err_trunc_d;

    logic [3:0]        arb_grant;
    logic              arb_any;
    logic              src_valid, src_last;
    logic [DATA_W-1:0] src_data, hdr_byte;

    uart_tx_pkt_arbiter_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
        .req       (i_req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .any_valid (arb_any)
    );

    assign hdr_byte = DATA_W'({HDR_MAGIC, grant_id_q});

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        chk_d          = chk_q;
        len_d          = len_q;
        err_trunc_d    = 1'b0;
        o_req_ready    = '0;
        o_fifo_wr_en   = 1'b0;
        o_fifo_wr_data = '0;
        src_valid      = 1'b0;
        src_last       = 1'b0;
        src_data       = '0;

        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id_q == 4'(k)) begin
                src_valid = i_req_valid[k];
                src_last  = i_req_last[k];
                src_data  = i_req_data[k*DATA_W +: DATA_W];
            end
        end

        unique case (state_q)
            ARB_IDLE: begin
                if (arb_any) begin
                    grant_id_d = arb_grant;
                    state_d    = ARB_HEADER;
                end
            end
            ARB_HEADER: begin
                if (!i_fifo_full) begin
                    o_fifo_wr_en   = 1'b1;
                    o_fifo_wr_data = hdr_byte;
                    chk_d          = hdr_byte;
                    len_d          = '0;
                    state_d        = ARB_PAYLOAD;
                end
            end
            ARB_PAYLOAD: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (grant_id_q == 4'(k)) begin
                        o_req_ready[k] = !i_fifo_full;
                    end
                end
                // Payload bytes pass straight through to the FIFO in the accept cycle.
                if (src_valid && !i_fifo_full) begin
                    o_fifo_wr_en   = 1'b1;
                    o_fifo_wr_data = src_data;
                    chk_d          = DATA_W'(chk_fold(CHK_MAX_W'(chk_q), CHK_MAX_W'(src_data)));
                    len_d          = len_q + 8'd1;
                    if (src_last) begin
                        state_d = ARB_TRAILER;
                    end else if (len_q + 8'd1 == 8'(MAX_PKT_LEN)) begin
                        state_d     = ARB_TRAILER;
                        err_trunc_d = 1'b1;
                    end
                end
            end
            ARB_TRAILER: begin
                if (!i_fifo_full) begin
                    o_fifo_wr_en   = 1'b1;
                    o_fifo_wr_data = chk_q;
                    rr_ptr_d       = (grant_id_q == 4'(NUM_REQ - 1)) ? 4'd0 : grant_id_q + 4'd1;
                    len_d          = '0;
                    state_d        = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            chk_q       <= '0;
            len_q       <= '0;
            err_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            chk_q       <= chk_d;
            len_q       <= len_d;
            err_trunc_q <= err_trunc_d;
        end
    end

    assign o_busy      = (state_q != ARB_IDLE);
    assign o_grant_id  = grant_id_q;
    assign o_err_trunc = err_trunc_q;

endmodule

// File: tb/tb_uart_tx_pkt_arbiter.sv
// Bench for uart_tx_pkt_arbiter: source queues feed the DUT, expected FIFO
// bytes sit in a scoreboard queue and are checked as each write appears.
module tb_uart_tx_pkt_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      wr_en;
    logic [DATA_W-1:0]         wr_data;
    logic                      busy;
    logic [3:0]                grant_id;
    logic                      err_trunc;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        int         src;
        int         n;
        logic [47:0] b;
        logic [7:0] chk;
    } vec_t;

    beat_t      src0_q[$];
    beat_t      src1_q[$];
    logic [7:0] exp_q[$];
    logic       acc0, acc1;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         err_cnt = 0;
    vec_t       vt[5];

    always #5 clk = ~clk;

    uart_tx_pkt_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .HDR_MAGIC   (4'hA),
        .MAX_PKT_LEN (MAX_LEN)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .i_req_data     (req_data),
        .i_req_last     (req_last),
        .o_req_ready    (req_ready),
        .i_fifo_full    (fifo_full),
        .o_fifo_wr_en   (wr_en),
        .o_fifo_wr_data (wr_data),
        .o_busy         (busy),
        .o_grant_id     (grant_id),
        .o_err_trunc    (err_trunc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Monitor: mid-cycle sample of writes and handshakes.
    initial begin
        acc0 = 1'b0;
        acc1 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc0 = 1'b0;
                acc1 = 1'b0;
            end else begin
                if (err_trunc) err_cnt++;
                check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
                if (wr_en) begin
                    if (fifo_full) check("write_while_full", 32'(wr_en), 32'd0);
                    if (exp_q.size() == 0) check("unexpected_write", 32'(wr_data), 32'h100);
                    else check("fifo_byte", 32'(wr_data), 32'(exp_q.pop_front()));
                end else begin
                    check("idle_data_zero", 32'(wr_data), 32'd0);
                end
                acc0 = req_valid[0] & req_ready[0];
                acc1 = req_valid[1] & req_ready[1];
            end
        end
    end

    // Source driver: pops accepted beats and presents the next one.
    initial begin
        beat_t drop;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (acc0 && src0_q.size() > 0) drop = src0_q.pop_front();
            if (acc1 && src1_q.size() > 0) drop = src1_q.pop_front();
            req_valid[0]    = (src0_q.size() > 0);
            req_data[7:0]   = (src0_q.size() > 0) ? src0_q[0].data : 8'h00;
            req_last[0]     = (src0_q.size() > 0) ? src0_q[0].last : 1'b0;
            req_valid[1]    = (src1_q.size() > 0);
            req_data[15:8]  = (src1_q.size() > 0) ? src1_q[0].data : 8'h00;
            req_last[1]     = (src1_q.size() > 0) ? src1_q[0].last : 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic q_src(input int src, input int n, input logic [47:0] b);
        beat_t bt;
        for (int i = 0; i < n; i++) begin
            bt.data = b[47-8*i -: 8];
            bt.last = (i == n - 1);
            if (src == 0) src0_q.push_back(bt);
            else          src1_q.push_back(bt);
        end
    endtask

    task automatic q_exp(input int id, input int n, input logic [47:0] b, input int off, input logic [7:0] c);
        exp_q.push_back({4'hA, 4'(id)});
        for (int i = 0; i < n; i++) exp_q.push_back(b[47-8*(off+i) -: 8]);
        exp_q.push_back(c);
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_left(input int left, input int budget);
        int c;
        c = 0;
        while (exp_q.size() > left && c < budget) begin
            tick();
            c++;
        end
        check("progress", 32'(exp_q.size()), 32'(left));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        fifo_full = 1'b0;
        src0_q.delete();
        src1_q.delete();
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        fifo_full = 1'b0;
        vt[0] = '{0, 2, 48'h1234_0000_0000, 8'h86};
        vt[1] = '{1, 1, 48'h5500_0000_0000, 8'hF4};
        vt[2] = '{0, 4, 48'h0102_0304_0000, 8'hA4};
        vt[3] = '{1, 1, 48'h0000_0000_0000, 8'hA1};
        vt[4] = '{0, 3, 48'hFFFF_FF00_0000, 8'h5F};

        repeat (3) tick();
        @(negedge clk);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en),     32'd0);
        check("rst_data",  32'(wr_data),   32'd0);
        check("rst_grant", 32'(grant_id),  32'd0);
        check("rst_err",   32'(err_trunc), 32'd0);
        rst = 1'b0;
        tick();

        // Table: single-source packets, including one that ends exactly at MAX_LEN.
        for (int i = 0; i < 5; i++) begin
            base = err_cnt;
            q_src(vt[i].src, vt[i].n, vt[i].b);
            q_exp(vt[i].src, vt[i].n, vt[i].b, 0, vt[i].chk);
            wait_drain(60);
            @(negedge clk);
            check("vec_grant", 32'(grant_id), 32'(vt[i].src));
            check("vec_busy",  32'(busy),     32'd0);
            check("vec_err",   32'(err_cnt - base), 32'd0);
            tick();
        end

        // Both sources request together from reset: no interleave, one idle cycle.
        do_reset();
        q_src(0, 2, 48'h1234_0000_0000);
        q_src(1, 1, 48'h5600_0000_0000);
        q_exp(0, 2, 48'h1234_0000_0000, 0, 8'h86);
        q_exp(1, 1, 48'h5600_0000_0000, 0, 8'hF7);
        wait_left(3, 60);
        @(negedge clk);
        check("gap_busy",  32'(busy),  32'd0);
        check("gap_wr_en", 32'(wr_en), 32'd0);
        @(negedge clk);
        check("hdr1_wr_en", 32'(wr_en),   32'd1);
        check("hdr1_data",  32'(wr_data), 32'hA1);
        wait_drain(60);
        check("contend_grant", 32'(grant_id), 32'd1);

        // FIFO full for 5 cycles mid-payload.
        q_src(0, 3, 48'h1122_3300_0000);
        q_exp(0, 3, 48'h1122_3300_0000, 0, 8'hA0);
        wait_left(3, 60);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_wr_en", 32'(wr_en),     32'd0);
            check("stall_busy",  32'(busy),      32'd1);
        end
        tick();
        fifo_full = 1'b0;
        wait_drain(60);

        // Packet longer than MAX_LEN is cut; tail goes out as its own packet.
        base = err_cnt;
        q_src(1, 6, 48'h0102_0304_0506);
        q_exp(1, 4, 48'h0102_0304_0506, 0, 8'hA5);
        q_exp(1, 2, 48'h0102_0304_0506, 4, 8'hA2);
        wait_drain(100);
        check("trunc_pulses", 32'(err_cnt - base), 32'd1);
        check("trunc_grant",  32'(grant_id),       32'd1);

        // Reset after two payload bytes abandons the packet.
        q_src(0, 4, 48'h0102_0304_0000);
        q_exp(0, 4, 48'h0102_0304_0000, 0, 8'hA4);
        wait_left(3, 60);
        rst = 1'b1;
        src0_q.delete();
        src1_q.delete();
        exp_q.delete();
        tick();
        @(negedge clk);
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_wr_en", 32'(wr_en),     32'd0);
        tick();
        rst = 1'b0;
        q_src(0, 2, 48'h0A0B_0000_0000);
        q_exp(0, 2, 48'h0A0B_0000_0000, 0, 8'hA1);
        wait_drain(60);
        check("restart_grant", 32'(grant_id), 32'd0);

        // Both sources continuously busy: grants alternate 0,1,0,1.
        do_reset();
        q_src(0, 2, 48'h1011_0000_0000);
        q_src(0, 3, 48'h3031_3200_0000);
        q_src(1, 1, 48'h2000_0000_0000);
        q_src(1, 2, 48'h4041_0000_0000);
        q_exp(0, 2, 48'h1011_0000_0000, 0, 8'hA1);
        q_exp(1, 1, 48'h2000_0000_0000, 0, 8'h81);
        q_exp(0, 3, 48'h3031_3200_0000, 0, 8'h93);
        q_exp(1, 2, 48'h4041_0000_0000, 0, 8'hA0);
        wait_drain(200);
        check("fair_grant", 32'(grant_id), 32'd1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
